unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

- Shares one single-port synchronous memory between the CPU instruction-fetch port and data port.
- Sits between `cpu_top` and the unified instruction/data RAM.
- Grants at most one access per cycle, with data priority and starvation protection for fetch.
- Tracks in-flight reads through a latency pipeline so each read return is routed to its owner.

## Interface
- `MEM_WORDS`, 1024: memory depth in 32-bit words; byte addresses ≥ 4*MEM_WORDS are out-of-bounds (OOB).
- `READ_LAT`, 1: memory read latency in cycles, legal 1..4.
- `MAX_DATA_BURST`, 4: maximum consecutive data grants while fetch waits.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_req`  in  1  fetch request; held with `i_addr` until `i_gnt`.
- `i_addr`  in  32  fetch byte address.
- `i_gnt`  out  1  fetch accepted this cycle.
- `i_rvalid`  out  1  fetch data valid.
- `i_rdata`  out  32  fetch data.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  write data.
- `d_wen`  in  4  byte enables; 4'b0000 means read.
- `d_gnt`  out  1  data accepted this cycle.
- `d_rvalid`  out  1  data read valid.
- `d_rdata`  out  32  data read value.
- `m_en`  out  1  memory access strobe.
- `m_we`  out  4  memory byte write enables.
- `m_addr`  out  32  memory byte address, bits [1:0] forced to 0.
- `m_wdata`  out  32  memory write data.
- `m_rdata`  in  32  memory read data, valid READ_LAT cycles after the `m_en` read.
- `oob_err`  out  1  one-cycle pulse for an OOB access.
- `conflict_cnt`  out  16  saturating count of cycles with `i_req` and `d_req` both high.

## Operation
- Arbitration is combinational (Mealy); state is `starve_cnt`, the return pipeline and `conflict_cnt`.
  - Only one requester active: grant it.
  - Both active: grant data, unless `starve_cnt == MAX_DATA_BURST`, then grant fetch.
- `starve_cnt`:
  - Increments on a data grant while `i_req` is high; saturates at `MAX_DATA_BURST`.
  - Clears on a fetch grant or in any cycle `i_req` is low.
- Granted access, in-bounds:
  - `m_en` = 1; `m_addr` = {addr[31:2], 2'b00}.
  - `m_we` = `d_wen` for data, 0 for fetch; `m_wdata` = `d_wdata`.
- Granted access, OOB:
  - `m_en` = 0, so no memory access occurs and the write is dropped.
  - The access is still tracked in the pipeline.
- Return pipeline: READ_LAT stages of {valid, owner, is_read, oob}, loaded on every grant.
- At the pipeline head:
  - Owner read valid → owner `rvalid` = 1.
  - `rdata` = `m_rdata`, or 32'hDEADBEEF if oob.
  - `oob_err` = oob, for reads and writes alike.
  - Writes produce no `rvalid`.
- `rdata` outputs are 0 whenever the matching `rvalid` is 0.
- Requesters may drop `req` before grant (withdrawal); no side effects.
- `conflict_cnt` increments every cycle both reqs are high and saturates at 16'hFFFF.

## Timing
- Grant and `m_*` outputs are combinational in the request cycle; memory samples at the next posedge.
- Read return: `rvalid` is high exactly READ_LAT cycles after the grant cycle.
- Throughput is one access per cycle; back-to-back grants are allowed, including alternating owners.
- `i_rvalid` and `d_rvalid` are never high together.
- While `rst_n` = 0:
  - All gnt, rvalid, rdata, `m_en`, `m_we` and `oob_err` outputs are forced to 0.
  - On the clock edge, the pipeline, `starve_cnt` and `conflict_cnt` clear.
- Reset mid-operation: in-flight reads are discarded and never return; the first grant is allowed in the first cycle with `rst_n` = 1.
- A fetch grant cannot be starved beyond MAX_DATA_BURST+1 cycles of continuous contention.

## Test plan
- Fetch only, READ_LAT=1, `i_addr`=0x8, mem[2]=0x00500093: `i_gnt` same cycle, `m_addr`=0x8; next cycle `i_rvalid`=1, `i_rdata`=0x00500093.
- Data write 0x37 to 0x200 with `d_wen`=4'b1111, then a read of 0x200: write cycle `m_we`=4'hF with no `d_rvalid`; the read returns `d_rdata`=0x37 one cycle after its grant.
- Both reqs held for 12 cycles, MAX_DATA_BURST=4:
  - Grant pattern is D,D,D,D,I repeating.
  - Returns are routed to the correct owner.
  - `conflict_cnt`=12.
- OOB reads at 0x1000 (fetch) and 0x2000 (data):
  - `m_en`=0 on both grants.
  - Each return carries 0xDEADBEEF with `oob_err`=1 and `rvalid` for the owner.
  - An OOB write gives `oob_err`=1 with no `rvalid` and memory unchanged.
- READ_LAT=3 with back-to-back fetch/data reads issued in cycles 0 and 1:
  - `i_rvalid` at cycle 3, `d_rvalid` at cycle 4, data correct.
  - `rst_n` pulsed low at cycle 2 suppresses both returns; counters read 0.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between CPU fetch and data ports.
// Data has priority. Fetch is forced through after MAX_DATA_BURST consecutive data wins.
module unified_mem_arbiter #(
  parameter int MEM_WORDS      = 1024,
  parameter int READ_LAT       = 1,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wen,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic [3:0]  m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        oob_err,
  output logic [15:0] conflict_cnt
);

  localparam int          SW         = $clog2(MAX_DATA_BURST + 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  typedef struct packed {
    logic valid;
    logic owner_d;
    logic is_read;
    logic oob;
  } ret_t;

  logic [SW-1:0] starve_cnt;
  ret_t          pipe_q [READ_LAT];
  ret_t          head;
  ret_t          new_entry;
  logic          grant_i;
  logic          grant_d;
  logic          granted;
  logic          acc_oob;
  logic          head_live;
  logic [31:0]   acc_addr;
  logic [31:0]   ret_data;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst_n) begin
      if (i_req && (!d_req || starve_cnt == SW'(MAX_DATA_BURST))) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  assign granted  = grant_i | grant_d;
  assign acc_addr = grant_i ? i_addr : d_addr;
  assign acc_oob  = (acc_addr >= ADDR_LIMIT);
  assign i_gnt    = grant_i;
  assign d_gnt    = grant_d;

  // Out-of-bounds accesses never reach the RAM, but they still travel down the return pipeline.
  always_comb begin
    m_en    = granted && !acc_oob;
    m_we    = (grant_d && !acc_oob) ? d_wen : 4'b0000;
    m_addr  = {acc_addr[31:2], 2'b00};
    m_wdata = d_wdata;
  end

  always_comb begin
    new_entry         = '0;
    new_entry.valid   = granted;
    new_entry.owner_d = grant_d;
    new_entry.is_read = grant_i || (d_wen == 4'b0000);
    new_entry.oob     = acc_oob;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_q[i] <= '0;
      end
      starve_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      pipe_q[0] <= new_entry;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      if (!i_req || grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && starve_cnt != SW'(MAX_DATA_BURST)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
      if (i_req && d_req && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

  // The head of the pipeline lines up with the RAM's read data for that access.
  assign head      = pipe_q[READ_LAT-1];
  assign head_live = rst_n && head.valid;
  assign ret_data  = head.oob ? 32'hDEADBEEF : m_rdata;
  assign i_rvalid  = head_live && !head.owner_d && head.is_read;
  assign d_rvalid  = head_live && head.owner_d && head.is_read;
  assign i_rdata   = i_rvalid ? ret_data : 32'h0;
  assign d_rdata   = d_rvalid ? ret_data : 32'h0;
  assign oob_err   = head_live && head.oob;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed and random traffic against a queue-based model.
// A second instance with READ_LAT=3 covers the long-latency and mid-flight reset cases.
module tb_unified_mem_arbiter;

  localparam int          MEM_WORDS = 1024;
  localparam int          MAX_BURST = 4;
  localparam int          LAT1      = 1;
  localparam logic [31:0] OOB_BASE  = 32'(4 * MEM_WORDS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, i_req, i_gnt, i_rvalid, d_req, d_gnt, d_rvalid, m_en, oob_err;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  d_wen, m_we;
  logic [15:0] conflict_cnt;

  logic        t3_rst_n, t3_i_req, t3_i_gnt, t3_i_rvalid, t3_d_req, t3_d_gnt, t3_d_rvalid;
  logic        t3_m_en, t3_oob_err;
  logic [31:0] t3_i_addr, t3_i_rdata, t3_d_addr, t3_d_rdata, t3_m_addr, t3_m_wdata, t3_m_rdata;
  logic [3:0]  t3_m_we;
  logic [15:0] t3_conflict_cnt;

  unified_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .READ_LAT(LAT1), .MAX_DATA_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wen(d_wen),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .oob_err(oob_err), .conflict_cnt(conflict_cnt)
  );

  unified_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .READ_LAT(3), .MAX_DATA_BURST(MAX_BURST)) dut3 (
    .clk(clk), .rst_n(t3_rst_n),
    .i_req(t3_i_req), .i_addr(t3_i_addr), .i_gnt(t3_i_gnt), .i_rvalid(t3_i_rvalid),
    .i_rdata(t3_i_rdata),
    .d_req(t3_d_req), .d_addr(t3_d_addr), .d_wdata(32'h0), .d_wen(4'b0000),
    .d_gnt(t3_d_gnt), .d_rvalid(t3_d_rvalid), .d_rdata(t3_d_rdata),
    .m_en(t3_m_en), .m_we(t3_m_we), .m_addr(t3_m_addr), .m_wdata(t3_m_wdata),
    .m_rdata(t3_m_rdata), .oob_err(t3_oob_err), .conflict_cnt(t3_conflict_cnt)
  );

  function automatic logic [31:0] init_word(input int k);
    if (k == 2) return 32'h00500093;
    return 32'hC0DE0000 + 32'(k * 7);
  endfunction

  // Behavioural RAMs attached to each instance; contents are loaded on the first clock edge.
  logic [31:0] ram1 [MEM_WORDS];
  logic [31:0] ram3 [MEM_WORDS];
  logic [31:0] rd1;
  logic [31:0] rd3 [3];
  logic        ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < MEM_WORDS; k++) begin
        ram1[k] <= init_word(k);
        ram3[k] <= init_word(k);
      end
      ram_loaded <= 1'b1;
    end else begin
      if (m_en) begin
        if (m_we == 4'b0000) rd1 <= ram1[m_addr[11:2]];
        for (int b = 0; b < 4; b++)
          if (m_we[b]) ram1[m_addr[11:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
      if (t3_m_en && t3_m_we == 4'b0000) rd3[0] <= ram3[t3_m_addr[11:2]];
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
    end
  end

  assign m_rdata    = rd1;
  assign t3_m_rdata = rd3[2];

  typedef struct {
    int          due;
    bit          owner_d;
    bit          is_read;
    bit          oob;
    logic [31:0] data;
  } exp_ret_t;

  exp_ret_t    ret_q[$];
  logic [31:0] ref_mem [MEM_WORDS];
  int          starve, conflict, cyc;
  int          checks, errors;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle on the READ_LAT=1 instance: drive, check at the falling edge, advance the model.
  task automatic applyStimulus(input bit rst_act, input bit ir, input logic [31:0] ia,
                               input bit dr, input logic [31:0] da,
                               input logic [31:0] wd, input logic [3:0] we);
    bit          eg_i, eg_d, eoob, eacc, head_ok, e_irv, e_drv, e_oob;
    logic [31:0] eaddr, e_data;
    exp_ret_t    ent;
    @(posedge clk);
    #1;
    rst_n = ~rst_act; i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wdata = wd; d_wen = we;
    @(negedge clk);
    eg_i = 1'b0; eg_d = 1'b0;
    if (!rst_act) begin
      if (ir && dr) begin
        if (starve == MAX_BURST) eg_i = 1'b1; else eg_d = 1'b1;
      end else if (ir) eg_i = 1'b1;
      else if (dr) eg_d = 1'b1;
    end
    eaddr = eg_i ? ia : da;
    eoob  = (eaddr >= OOB_BASE);
    eacc  = (eg_i || eg_d) && !eoob;
    checkOutput("i_gnt", 32'(i_gnt), 32'(eg_i));
    checkOutput("d_gnt", 32'(d_gnt), 32'(eg_d));
    checkOutput("m_en", 32'(m_en), 32'(eacc));
    checkOutput("m_we", 32'(m_we), (eacc && eg_d) ? 32'(we) : 32'h0);
    if (eacc) checkOutput("m_addr", m_addr, eaddr & ~32'h3);
    if (eacc && eg_d && we != 4'b0000) checkOutput("m_wdata", m_wdata, wd);
    head_ok = !rst_act && ret_q.size() > 0 && ret_q[0].due == cyc;
    e_irv = 1'b0; e_drv = 1'b0; e_oob = 1'b0; e_data = 32'h0;
    if (head_ok) begin
      e_irv  = !ret_q[0].owner_d && ret_q[0].is_read;
      e_drv  = ret_q[0].owner_d && ret_q[0].is_read;
      e_oob  = ret_q[0].oob;
      e_data = ret_q[0].data;
    end
    checkOutput("i_rvalid", 32'(i_rvalid), 32'(e_irv));
    checkOutput("i_rdata", i_rdata, e_irv ? e_data : 32'h0);
    checkOutput("d_rvalid", 32'(d_rvalid), 32'(e_drv));
    checkOutput("d_rdata", d_rdata, e_drv ? e_data : 32'h0);
    checkOutput("oob_err", 32'(oob_err), 32'(e_oob));
    checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(conflict));
    if (rst_act) begin
      ret_q.delete();
      starve   = 0;
      conflict = 0;
    end else begin
      if (ret_q.size() > 0 && ret_q[0].due == cyc) void'(ret_q.pop_front());
      if (eg_i || eg_d) begin
        ent.due     = cyc + LAT1;
        ent.owner_d = eg_d;
        ent.is_read = eg_i || (we == 4'b0000);
        ent.oob     = eoob;
        ent.data    = eoob ? 32'hDEADBEEF : ref_mem[eaddr[11:2]];
        ret_q.push_back(ent);
      end
      if (eg_d && !eoob)
        for (int b = 0; b < 4; b++)
          if (we[b]) ref_mem[eaddr[11:2]][8*b +: 8] = wd[8*b +: 8];
      if (ir && dr && conflict < 65535) conflict++;
      if (!ir || eg_i) starve = 0;
      else if (eg_d && starve < MAX_BURST) starve++;
    end
    cyc++;
  endtask

  task automatic l3Cycle(input bit rst_act, input bit ir, input logic [31:0] ia,
                         input bit dr, input logic [31:0] da);
    @(posedge clk);
    #1;
    t3_rst_n = ~rst_act; t3_i_req = ir; t3_i_addr = ia; t3_d_req = dr; t3_d_addr = da;
    @(negedge clk);
  endtask

  function automatic logic [31:0] random_addr();
    if ($urandom_range(0, 9) == 0) return OOB_BASE + 32'($urandom_range(0, 65535));
    return 32'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [31:0] fa;
    bit          r_rst, r_ir, r_dr;
    checks = 0; errors = 0; starve = 0; conflict = 0; cyc = 0;
    rst_n = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_addr = 32'h0;
    d_wdata = 32'h0; d_wen = 4'b0000;
    t3_rst_n = 1'b0; t3_i_req = 1'b0; t3_i_addr = 32'h0; t3_d_req = 1'b0; t3_d_addr = 32'h0;
    for (int k = 0; k < MEM_WORDS; k++) ref_mem[k] = init_word(k);

    $display("[TB] reset with both requests asserted");
    applyStimulus(1, 1, 32'h8, 1, 32'h20, 32'h0, 4'h0);
    applyStimulus(1, 1, 32'h8, 1, 32'h20, 32'h0, 4'h0);

    $display("[TB] single fetch");
    applyStimulus(0, 1, 32'h8, 0, 32'h0, 32'h0, 4'h0);
    checkOutput("plan_fetch_gnt", 32'(i_gnt), 32'd1);
    checkOutput("plan_fetch_maddr", m_addr, 32'h8);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    checkOutput("plan_fetch_rvalid", 32'(i_rvalid), 32'd1);
    checkOutput("plan_fetch_rdata", i_rdata, 32'h00500093);

    $display("[TB] data write then read");
    applyStimulus(0, 0, 32'h0, 1, 32'h200, 32'h37, 4'hF);
    checkOutput("plan_wr_mwe", 32'(m_we), 32'hF);
    applyStimulus(0, 0, 32'h0, 1, 32'h200, 32'h0, 4'h0);
    checkOutput("plan_wr_no_rvalid", 32'(d_rvalid), 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    checkOutput("plan_rd_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("plan_rd_rdata", d_rdata, 32'h37);

    $display("[TB] sustained contention");
    fa = 32'h100;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, fa, 1, 32'h300 + 32'(4 * k), 32'h0, 4'h0);
      checkOutput("plan_burst_ignt", 32'(i_gnt), 32'(k % 5 == 4));
      if (i_gnt) fa = fa + 32'h4;
    end
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    checkOutput("plan_conflict12", 32'(conflict_cnt), 32'd12);

    $display("[TB] out-of-bounds accesses");
    applyStimulus(0, 1, 32'h1000, 0, 32'h0, 32'h0, 4'h0);
    checkOutput("plan_oob_i_men", 32'(m_en), 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 32'h2000, 32'h0, 4'h0);
    checkOutput("plan_oob_d_men", 32'(m_en), 32'd0);
    checkOutput("plan_oob_i_rdata", i_rdata, 32'hDEADBEEF);
    applyStimulus(0, 0, 32'h0, 1, 32'h1004, 32'hFFFFFFFF, 4'hF);
    checkOutput("plan_oob_d_rdata", d_rdata, 32'hDEADBEEF);
    checkOutput("plan_oob_wr_men", 32'(m_en), 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    checkOutput("plan_oob_wr_err", 32'(oob_err), 32'd1);
    checkOutput("plan_oob_wr_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("plan_oob_ram_intact", ram1[1], init_word(1));

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      r_ir  = ($urandom_range(0, 9) < 6);
      r_dr  = ($urandom_range(0, 9) < 6);
      applyStimulus(r_rst, r_ir, random_addr(), r_dr, random_addr(), $urandom,
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
    end
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0);

    $display("[TB] READ_LAT=3 back-to-back reads");
    l3Cycle(0, 1, 32'h10, 0, 32'h0);
    checkOutput("l3_i_gnt", 32'(t3_i_gnt), 32'd1);
    checkOutput("l3_maddr", t3_m_addr, 32'h10);
    l3Cycle(0, 0, 32'h0, 1, 32'h14);
    checkOutput("l3_d_gnt", 32'(t3_d_gnt), 32'd1);
    l3Cycle(0, 0, 32'h0, 0, 32'h0);
    checkOutput("l3_c2_irv", 32'(t3_i_rvalid), 32'd0);
    l3Cycle(0, 0, 32'h0, 0, 32'h0);
    checkOutput("l3_c3_irv", 32'(t3_i_rvalid), 32'd1);
    checkOutput("l3_c3_irdata", t3_i_rdata, init_word(4));
    checkOutput("l3_c3_drv", 32'(t3_d_rvalid), 32'd0);
    l3Cycle(0, 0, 32'h0, 0, 32'h0);
    checkOutput("l3_c4_drv", 32'(t3_d_rvalid), 32'd1);
    checkOutput("l3_c4_drdata", t3_d_rdata, init_word(5));
    checkOutput("l3_c4_irv", 32'(t3_i_rvalid), 32'd0);
    l3Cycle(0, 0, 32'h0, 0, 32'h0);
    checkOutput("l3_c5_drv", 32'(t3_d_rvalid), 32'd0);

    $display("[TB] READ_LAT=3 reset while reads are in flight");
    l3Cycle(0, 1, 32'h10, 0, 32'h0);
    l3Cycle(0, 0, 32'h0, 1, 32'h14);
    l3Cycle(1, 1, 32'h10, 1, 32'h14);
    checkOutput("l3r_i_gnt", 32'(t3_i_gnt), 32'd0);
    checkOutput("l3r_d_gnt", 32'(t3_d_gnt), 32'd0);
    checkOutput("l3r_men", 32'(t3_m_en), 32'd0);
    l3Cycle(0, 1, 32'h10, 0, 32'h0);
    checkOutput("l3r_c3_irv", 32'(t3_i_rvalid), 32'd0);
    checkOutput("l3r_first_gnt", 32'(t3_i_gnt), 32'd1);
    checkOutput("l3r_conflict", 32'(t3_conflict_cnt), 32'd0);
    l3Cycle(0, 0, 32'h0, 0, 32'h0);
    checkOutput("l3r_c4_drv", 32'(t3_d_rvalid), 32'd0);
    checkOutput("l3r_c4_irv", 32'(t3_i_rvalid), 32'd0);
    checkOutput("l3r_c4_conflict", 32'(t3_conflict_cnt), 32'd0);
    l3Cycle(0, 0, 32'h0, 0, 32'h0);
    checkOutput("l3r_c5_irv", 32'(t3_i_rvalid), 32'd0);
    l3Cycle(0, 0, 32'h0, 0, 32'h0);
    checkOutput("l3r_c6_irv", 32'(t3_i_rvalid), 32'd1);
    checkOutput("l3r_c6_irdata", t3_i_rdata, init_word(4));
    checkOutput("l3r_c6_oob", 32'(t3_oob_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
